// File: rtl/mouse_pos_sync.sv
// Moves mouse x/y/left from the controller domain onto the pixel clock and presents
// frame-stable values latched at vblank start. Define MOUSE_CLAMP_EN to clamp x/y to H_MAX/V_MAX.
module mouse_pos_sync #(
  parameter int unsigned WIDTH       = 12,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned STABLE_CNT  = 3,
  parameter int unsigned H_MAX       = 1023,
  parameter int unsigned V_MAX       = 767
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] xpos_in,
  input  logic [WIDTH-1:0] ypos_in,
  input  logic             left_in,
  input  logic             vblnk_in,
  output logic [WIDTH-1:0] xpos_out,
  output logic [WIDTH-1:0] ypos_out,
  output logic             click_out,
  output logic             valid_out
);

  localparam int unsigned CntW = $clog2(STABLE_CNT + 1);

  if (SYNC_STAGES < 2 || STABLE_CNT < 1 || (H_MAX >> WIDTH) != 0 || (V_MAX >> WIDTH) != 0)
  begin : g_bad_params
    $error("mouse_pos_sync: illegal parameter value");
  end

  logic [SYNC_STAGES-1:0][WIDTH-1:0] xsync_q, xsync_d, ysync_q, ysync_d;
  logic [SYNC_STAGES-1:0]            lsync_q, lsync_d;
  logic [2*WIDTH-1:0]                prev_q, prev_d;
  logic [CntW-1:0]                   cnt_q, cnt_d;
  logic [WIDTH-1:0]                  acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic                              ls_prev_q, ls_prev_d;
  logic                              pend_q, pend_d;
  logic                              vblnk_low_q, vblnk_low_d;
  logic [WIDTH-1:0]                  xpos_q, xpos_d, ypos_q, ypos_d;
  logic                              click_q, click_d, valid_q, valid_d;

  logic [WIDTH-1:0] xs, ys, x_lim, y_lim;
  logic             ls, same, load, rise, lat;

  assign xs = xsync_q[SYNC_STAGES-1];
  assign ys = ysync_q[SYNC_STAGES-1];
  assign ls = lsync_q[SYNC_STAGES-1];

  always_comb begin
    xsync_d = {xsync_q[SYNC_STAGES-2:0], xpos_in};
    ysync_d = {ysync_q[SYNC_STAGES-2:0], ypos_in};
    lsync_d = {lsync_q[SYNC_STAGES-2:0], left_in};
  end

`ifdef MOUSE_CLAMP_EN
  always_comb begin
    x_lim = (xs > WIDTH'(H_MAX)) ? WIDTH'(H_MAX) : xs;
    y_lim = (ys > WIDTH'(V_MAX)) ? WIDTH'(V_MAX) : ys;
  end
`else
  always_comb begin
    x_lim = xs;
    y_lim = ys;
  end
`endif

  // A value is accepted once it has been seen on STABLE_CNT+1 consecutive samples.
  always_comb begin
    same    = ({xs, ys} == prev_q);
    load    = same && (cnt_q == CntW'(STABLE_CNT - 1));
    prev_d  = {xs, ys};
    cnt_d   = cnt_q;
    acc_x_d = acc_x_q;
    acc_y_d = acc_y_q;
    if (!same) begin
      cnt_d = '0;
    end else if (cnt_q != CntW'(STABLE_CNT)) begin
      cnt_d = cnt_q + CntW'(1);
    end
    if (load) begin
      acc_x_d = x_lim;
      acc_y_d = y_lim;
    end
  end

  // vblnk_low_q resets to 0, so a vblank already high at reset release never latches.
  always_comb begin
    rise        = ls & ~ls_prev_q;
    lat         = vblnk_in & vblnk_low_q;
    ls_prev_d   = ls;
    vblnk_low_d = ~vblnk_in;
    xpos_d      = xpos_q;
    ypos_d      = ypos_q;
    valid_d     = valid_q;
    click_d     = 1'b0;
    pend_d      = pend_q | rise;
    if (lat) begin
      xpos_d  = acc_x_q;
      ypos_d  = acc_y_q;
      valid_d = 1'b1;
      click_d = pend_q;
      pend_d  = rise;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xsync_q     <= '0;
      ysync_q     <= '0;
      lsync_q     <= '0;
      prev_q      <= '0;
      cnt_q       <= '0;
      acc_x_q     <= '0;
      acc_y_q     <= '0;
      ls_prev_q   <= 1'b0;
      pend_q      <= 1'b0;
      vblnk_low_q <= 1'b0;
      xpos_q      <= '0;
      ypos_q      <= '0;
      click_q     <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      xsync_q     <= xsync_d;
      ysync_q     <= ysync_d;
      lsync_q     <= lsync_d;
      prev_q      <= prev_d;
      cnt_q       <= cnt_d;
      acc_x_q     <= acc_x_d;
      acc_y_q     <= acc_y_d;
      ls_prev_q   <= ls_prev_d;
      pend_q      <= pend_d;
      vblnk_low_q <= vblnk_low_d;
      xpos_q      <= xpos_d;
      ypos_q      <= ypos_d;
      click_q     <= click_d;
      valid_q     <= valid_d;
    end
  end

  assign xpos_out  = xpos_q;
  assign ypos_out  = ypos_q;
  assign click_out = click_q;
  assign valid_out = valid_q;

endmodule

// File: tb/tb_mouse_pos_sync.sv
// Bench for mouse_pos_sync: directed scenarios plus a randomized run against a
// history-window reference model. Honours MOUSE_CLAMP_EN like the design.
module tb_mouse_pos_sync;

  localparam int unsigned W = 12;
  localparam int unsigned S = 2;
  localparam int unsigned C = 3;
  localparam int unsigned HMax = 1023;
  localparam int unsigned VMax = 767;

  logic         clk, rst;
  logic [W-1:0] xpos_in, ypos_in;
  logic         left_in, vblnk_in;
  logic [W-1:0] xpos_out, ypos_out;
  logic         click_out, valid_out;

  int n_checks = 0;
  int n_pass   = 0;

  mouse_pos_sync dut (
    .clk      (clk),
    .rst      (rst),
    .xpos_in  (xpos_in),
    .ypos_in  (ypos_in),
    .left_in  (left_in),
    .vblnk_in (vblnk_in),
    .xpos_out (xpos_out),
    .ypos_out (ypos_out),
    .click_out(click_out),
    .valid_out(valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: index k of the history = value applied k clock edges ago.
  logic [2*W-1:0] m_hxy [0:S+C];
  logic           m_hl  [0:S+C];
  logic [W-1:0]   m_ax, m_ay, m_xo, m_yo;
  logic           m_pend, m_click, m_valid, m_vlow;

  task automatic model_reset();
    for (int k = 0; k <= S + C; k++) begin
      m_hxy[k] = '0;
      m_hl[k]  = 1'b0;
    end
    m_ax = '0; m_ay = '0; m_xo = '0; m_yo = '0;
    m_pend = 1'b0; m_click = 1'b0; m_valid = 1'b0; m_vlow = 1'b0;
  endtask

  task automatic model_step(input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic l, input logic v);
    logic lat, rise, stable;
    logic [W-1:0] sx, sy;
    lat = v && m_vlow;
    for (int k = S + C; k > 0; k--) begin
      m_hxy[k] = m_hxy[k-1];
      m_hl[k]  = m_hl[k-1];
    end
    m_hxy[0] = {x, y};
    m_hl[0]  = l;
    rise   = m_hl[S] && !m_hl[S+1];
    stable = 1'b1;
    for (int k = S + 1; k <= S + C; k++) if (m_hxy[k] != m_hxy[S]) stable = 1'b0;
    if (lat) begin
      m_xo = m_ax; m_yo = m_ay; m_valid = 1'b1; m_click = m_pend; m_pend = rise;
    end else begin
      m_click = 1'b0; m_pend = m_pend | rise;
    end
    if (stable) begin
      {sx, sy} = m_hxy[S];
`ifdef MOUSE_CLAMP_EN
      if (sx > W'(HMax)) sx = W'(HMax);
      if (sy > W'(VMax)) sy = W'(VMax);
`endif
      m_ax = sx; m_ay = sy;
    end
    m_vlow = !v;
  endtask

  // Called at a negedge; returns at the next negedge.
  task automatic tick(input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic l, input logic v);
    xpos_in = x; ypos_in = y; left_in = l; vblnk_in = v;
    model_step(x, y, l, v);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; xpos_in = '0; ypos_in = '0; left_in = 1'b0; vblnk_in = 1'b0;
    model_reset();
    @(negedge clk);
    n_checks++;
    if ({xpos_out, ypos_out, click_out, valid_out} !== '0)
      $display("FAIL reset_outputs: got x=%0d y=%0d c=%0b v=%0b expected all 0",
               xpos_out, ypos_out, click_out, valid_out);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_hold_latch();
    for (int i = 0; i < 10; i++) tick(12'd100, 12'd200, 1'b0, 1'b0);
    n_checks++;
    if (valid_out !== 1'b0) $display("FAIL hold_valid_pre: got %0b expected 0", valid_out);
    else n_pass++;
    tick(12'd100, 12'd200, 1'b0, 1'b1);
    n_checks++;
    if (xpos_out !== 12'd100 || ypos_out !== 12'd200 || valid_out !== 1'b1)
      $display("FAIL hold_latch: got x=%0d y=%0d v=%0b expected x=100 y=200 v=1",
               xpos_out, ypos_out, valid_out);
    else n_pass++;
  endtask

  task automatic test_filter_toggle();
    for (int i = 0; i < 20; i++) tick((i % 2) ? 12'd6 : 12'd5, 12'd200, 1'b0, i >= 15);
    n_checks++;
    if (xpos_out !== 12'd100) $display("FAIL toggle_reject: got x=%0d expected 100", xpos_out);
    else n_pass++;
    for (int i = 0; i < 10; i++) tick(12'd7, 12'd200, 1'b0, 1'b0);
    tick(12'd7, 12'd200, 1'b0, 1'b1);
    n_checks++;
    if (xpos_out !== 12'd7) $display("FAIL toggle_settle: got x=%0d expected 7", xpos_out);
    else n_pass++;
  endtask

  task automatic test_click();
    for (int i = 0; i < 3; i++) tick(12'd7, 12'd200, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick(12'd7, 12'd200, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick(12'd7, 12'd200, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) tick(12'd7, 12'd200, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick(12'd7, 12'd200, 1'b0, 1'b0);
    n_checks++;
    if (click_out !== 1'b0) $display("FAIL click_early: got %0b expected 0", click_out);
    else n_pass++;
    // Third press reaches the synced domain exactly on the latch cycle.
    for (int i = 0; i < S; i++) tick(12'd7, 12'd200, 1'b1, 1'b0);
    tick(12'd7, 12'd200, 1'b1, 1'b1);
    n_checks++;
    if (click_out !== 1'b1) $display("FAIL click_first: got %0b expected 1", click_out);
    else n_pass++;
    tick(12'd7, 12'd200, 1'b1, 1'b1);
    n_checks++;
    if (click_out !== 1'b0) $display("FAIL click_pulse_len: got %0b expected 0", click_out);
    else n_pass++;
    for (int i = 0; i < 4; i++) tick(12'd7, 12'd200, 1'b0, 1'b0);
    tick(12'd7, 12'd200, 1'b0, 1'b1);
    n_checks++;
    if (click_out !== 1'b1) $display("FAIL click_deferred: got %0b expected 1", click_out);
    else n_pass++;
    tick(12'd7, 12'd200, 1'b0, 1'b1);
    n_checks++;
    if (click_out !== 1'b0) $display("FAIL click_deferred_len: got %0b expected 0", click_out);
    else n_pass++;
  endtask

  task automatic test_change_in_vblank();
    for (int i = 0; i < 8; i++) begin
      tick(12'd300, 12'd200, 1'b0, 1'b1);
      n_checks++;
      if (xpos_out !== 12'd7) $display("FAIL vblank_hold[%0d]: got x=%0d expected 7", i, xpos_out);
      else n_pass++;
    end
    tick(12'd300, 12'd200, 1'b0, 1'b0);
    tick(12'd300, 12'd200, 1'b0, 1'b1);
    n_checks++;
    if (xpos_out !== 12'd300) $display("FAIL vblank_next: got x=%0d expected 300", xpos_out);
    else n_pass++;
  endtask

  task automatic test_clamp();
    logic [W-1:0] ex, ey;
`ifdef MOUSE_CLAMP_EN
    ex = W'(HMax); ey = W'(VMax);
`else
    ex = 12'd1500; ey = 12'd900;
`endif
    for (int i = 0; i < 10; i++) tick(12'd1500, 12'd900, 1'b0, 1'b0);
    tick(12'd1500, 12'd900, 1'b0, 1'b1);
    n_checks++;
    if (xpos_out !== ex || ypos_out !== ey)
      $display("FAIL clamp: got x=%0d y=%0d expected x=%0d y=%0d", xpos_out, ypos_out, ex, ey);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    tick(12'd55, 12'd66, 1'b0, 1'b1);
    tick(12'd55, 12'd66, 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({xpos_out, ypos_out, click_out, valid_out} !== '0)
      $display("FAIL reset_mid: got x=%0d y=%0d c=%0b v=%0b expected all 0",
               xpos_out, ypos_out, click_out, valid_out);
    else n_pass++;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(12'd55, 12'd66, 1'b0, 1'b1);
      n_checks++;
      if (valid_out !== 1'b0) $display("FAIL reset_vblank_high[%0d]: got %0b expected 0", i, valid_out);
      else n_pass++;
    end
    tick(12'd55, 12'd66, 1'b0, 1'b0);
    tick(12'd55, 12'd66, 1'b0, 1'b1);
    n_checks++;
    if (valid_out !== 1'b1 || xpos_out !== 12'd55 || ypos_out !== 12'd66)
      $display("FAIL reset_relatch: got v=%0b x=%0d y=%0d expected v=1 x=55 y=66",
               valid_out, xpos_out, ypos_out);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [W-1:0] x, y;
    logic l, v;
    int vcnt;
    x = 12'd55; y = 12'd66; l = 1'b0; v = 1'b1; vcnt = 0;
    for (int i = 0; i < 800; i++) begin
      if (vcnt == 0) begin
        v = ~v;
        vcnt = v ? int'($urandom_range(2, 5)) : int'($urandom_range(6, 20));
      end
      vcnt--;
      if ($urandom_range(0, 9) < 2) x = W'($urandom_range(0, 4095));
      if ($urandom_range(0, 9) < 2) y = W'($urandom_range(0, 4095));
      if ($urandom_range(0, 4) == 0) l = ~l;
      tick(x, y, l, v);
      n_checks++;
      if (xpos_out !== m_xo || ypos_out !== m_yo || click_out !== m_click || valid_out !== m_valid)
        $display("FAIL rand[%0d]: got x=%0d y=%0d c=%0b v=%0b expected x=%0d y=%0d c=%0b v=%0b",
                 i, xpos_out, ypos_out, click_out, valid_out, m_xo, m_yo, m_click, m_valid);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_hold_latch();
    test_filter_toggle();
    test_click();
    test_change_in_vblank();
    test_clamp();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
